pc_return_stack: RTL and testbench

- Hardware return-address stack that feeds the return-address input of the 10-bit program-counter mux.
- CALL pushes the caller-supplied return address; RET/RETI pops it.
- Top of stack is presented combinationally, so the control unit can select it and assert PC load in the same cycle as the pop.
- Sits beside the PC stage, between the control unit (push/pop strobes) and the PC mux.

---
 rtl/rat_pkg.sv | 6 +
 rtl/rstack_regfile.sv | 27 ++
 rtl/pc_return_stack.sv | 78 +++++++
 tb/tb_pc_return_stack.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// rat_pkg: shared widths and the program-address type for the return-address stack.
package rat_pkg;
   localparam int PC_W = 10;
   localparam int RSTACK_DEPTH = 16;
   typedef logic [PC_W-1:0] pc_addr_t;
endpackage

// File: rtl/rstack_regfile.sv
// rstack_regfile: DEPTH x ADDR_W return-address array, one synchronous write port,
// one asynchronous read port, cleared asynchronously on rst.
module rstack_regfile
   import rat_pkg::*;
#(
   parameter int ADDR_W = PC_W,
   parameter int DEPTH  = RSTACK_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [ADDR_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [ADDR_W-1:0]        rdata
);
   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) mem_q <= '{default: '0};
      else mem_q <= mem_d;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/pc_return_stack.sv
// pc_return_stack: return-address stack feeding the PC mux; top of stack is combinational.
// Define RSTACK_WRAP_EN to make a push while full overwrite the oldest entry (circular buffer).
module pc_return_stack
   import rat_pkg::*;
#(
   parameter int ADDR_W = PC_W,
   parameter int DEPTH  = RSTACK_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic                       clr_err,
   output logic [ADDR_W-1:0]          ret_addr,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       empty,
   output logic                       full,
   output logic                       ovf,
   output logic                       unf
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DEPTH+1);
   logic [DW-1:0] depth_q, depth_d;
   logic ovf_q, ovf_d, unf_q, unf_d;
   logic [AW-1:0] bot, waddr, raddr;
   logic [ADDR_W-1:0] rdata;
   logic is_empty, is_full, repl, full_push, inc, dec, we;
   assign is_empty = depth_q == '0;
   assign is_full  = depth_q == DW'(DEPTH);
   // Entries live at bot .. bot+depth-1 (mod DEPTH); bot is fixed at 0 unless wrapping.
   always_comb begin
      repl      = push && pop && !is_empty;
      full_push = push && !pop && is_full;
      inc       = push && !is_full && !repl;
      dec       = pop && !push && !is_empty;
`ifdef RSTACK_WRAP_EN
      we        = push;
`else
      we        = push && !full_push;
`endif
      waddr     = bot + depth_q[AW-1:0] - AW'(repl);
      raddr     = bot + depth_q[AW-1:0] - AW'(1);
      depth_d   = inc ? depth_q + DW'(1) : dec ? depth_q - DW'(1) : depth_q;
      ovf_d     = full_push || (ovf_q && !clr_err);
      unf_d     = (pop && is_empty) || (unf_q && !clr_err);
   end
`ifdef RSTACK_WRAP_EN
   logic [AW-1:0] bot_q, bot_d;
   assign bot_d = bot_q + AW'(full_push);
   always_ff @(posedge clk or posedge rst)
      if (rst) bot_q <= '0;
      else bot_q <= bot_d;
   assign bot = bot_q;
`else
   assign bot = '0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   rstack_regfile #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_regfile (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(push_addr),
      .raddr(raddr), .rdata(rdata)
   );
   assign ret_addr = is_empty ? '0 : rdata;
   assign depth    = depth_q;
   assign empty    = is_empty;
   assign full     = is_full;
   assign ovf      = ovf_q;
   assign unf      = unf_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// tb_pc_return_stack: directed vectors checked against a queue-based stack model every cycle,
// plus literal expectations; honours RSTACK_WRAP_EN.
module tb_pc_return_stack;
   localparam int DEPTH = 16;
   logic clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
   logic [9:0] push_addr = '0;
   logic [9:0] ret_addr;
   logic [4:0] depth;
   logic empty, full, ovf, unf;
   int tests = 0, fails = 0;
   bit chk_en = 1'b0;
   logic [9:0] q[$];
   bit m_ovf = 1'b0, m_unf = 1'b0, m_e, m_f, set_o, set_u;

   pc_return_stack dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
      .clr_err(clr_err), .ret_addr(ret_addr), .depth(depth), .empty(empty),
      .full(full), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stack model: queue with the top at the back.
   always @(posedge clk or posedge rst)
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         m_e = q.size() == 0;
         m_f = q.size() == DEPTH;
         set_o = 1'b0;
         set_u = 1'b0;
         if (push && pop) begin
            if (m_e) begin
               q.push_back(push_addr);
               set_u = 1'b1;
            end else q[q.size()-1] = push_addr;
         end else if (push) begin
            if (!m_f) q.push_back(push_addr);
            else begin
               set_o = 1'b1;
`ifdef RSTACK_WRAP_EN
               void'(q.pop_front());
               q.push_back(push_addr);
`endif
            end
         end else if (pop) begin
            if (m_e) set_u = 1'b1;
            else void'(q.pop_back());
         end
         m_ovf = set_o || (m_ovf && !clr_err);
         m_unf = set_u || (m_unf && !clr_err);
      end

   always @(negedge clk)
      if (chk_en) begin
         check("model ret_addr", int'(ret_addr), q.size() ? int'(q[q.size()-1]) : 0);
         check("model depth", int'(depth), q.size());
         check("model empty", int'(empty), int'(q.size() == 0));
         check("model full", int'(full), int'(q.size() == DEPTH));
         check("model ovf", int'(ovf), int'(m_ovf));
         check("model unf", int'(unf), int'(m_unf));
      end

   task automatic drive(input bit pu, input bit po, input int a, input bit c);
      push = pu;
      pop = po;
      push_addr = 10'(a);
      clr_err = c;
   endtask

   task automatic step(input bit pu, input bit po, input int a, input bit c);
      drive(pu, po, a, c);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      check("reset ret_addr", int'(ret_addr), 0);
      check("reset depth", int'(depth), 0);
      check("reset empty", int'(empty), 1);
      check("reset ovf", int'(ovf), 0);
      check("reset unf", int'(unf), 0);
      step(1, 0, 'h012, 0);
      step(1, 0, 'h034, 0);
      step(1, 0, 'h3FF, 0);
      check("push3 depth", int'(depth), 3);
      check("push3 top", int'(ret_addr), 'h3FF);
      drive(0, 1, 0, 0);
      #1 check("pop same-cycle top", int'(ret_addr), 'h3FF);
      @(posedge clk);
      #1 drive(0, 0, 0, 0);
      check("pop next top", int'(ret_addr), 'h034);
      check("pop depth", int'(depth), 2);
      step(1, 1, 'h155, 0);
      check("replace depth", int'(depth), 2);
      check("replace top", int'(ret_addr), 'h155);
      step(0, 1, 0, 0);
      check("below replace", int'(ret_addr), 'h012);
      step(0, 1, 0, 0);
      check("drained empty", int'(empty), 1);
      step(0, 1, 0, 0);
      check("empty pop unf", int'(unf), 1);
      check("empty pop ret", int'(ret_addr), 0);
      check("empty pop depth", int'(depth), 0);
      step(0, 1, 0, 1);
      check("clr vs new unf", int'(unf), 1);
      step(0, 0, 0, 1);
      check("clr unf", int'(unf), 0);
      step(1, 1, 'h077, 0);
      check("pushpop empty depth", int'(depth), 1);
      check("pushpop empty unf", int'(unf), 1);
      check("pushpop empty top", int'(ret_addr), 'h077);
      step(0, 1, 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 0, 'h100 + i, 0);
      check("fill full", int'(full), 1);
      check("fill top", int'(ret_addr), 'h10F);
      step(1, 0, 'h2AA, 0);
      check("overflow ovf", int'(ovf), 1);
      check("overflow depth", int'(depth), 16);
`ifdef RSTACK_WRAP_EN
      check("overflow top", int'(ret_addr), 'h2AA);
`else
      check("overflow top", int'(ret_addr), 'h10F);
`endif
      step(0, 0, 0, 1);
      check("clr ovf", int'(ovf), 0);
      step(1, 1, 'h3A5, 0);
      check("full replace ovf", int'(ovf), 0);
      check("full replace top", int'(ret_addr), 'h3A5);
      check("full replace depth", int'(depth), 16);
      for (int i = 0; i < DEPTH; i++) begin
`ifdef RSTACK_WRAP_EN
         check("drain value", int'(ret_addr), i == 0 ? 'h3A5 : 'h110 - i);
`else
         check("drain value", int'(ret_addr), i == 0 ? 'h3A5 : 'h10F - i);
`endif
         step(0, 1, 0, 0);
      end
      check("drain empty", int'(empty), 1);
      for (int i = 0; i < 5; i++) step(1, 0, 'h200 + i, 0);
      check("pre-reset depth", int'(depth), 5);
      #2 rst = 1'b1;
      #1;
      check("async rst depth", int'(depth), 0);
      check("async rst empty", int'(empty), 1);
      check("async rst ret", int'(ret_addr), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 0, 'h0AB, 0);
      check("post-reset top", int'(ret_addr), 'h0AB);
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
